pcpi_initiator: RTL and testbench
=================================

# pcpi_initiator

Issue sequencer for the PCPI coprocessor port, on the CPU side of the interface that the M-extension unit serves. It accepts one custom/M instruction with operands from the core pipeline and drives pcpi_valid/insn/rs1/rs2 to an attached coprocessor. It waits for pcpi_ready, or declares the instruction illegal after a no-response timeout, and returns the result through a valid/ready response port. It also keeps per-operation latency and error statistics.

## Interface
Parameters:
- TIMEOUT, 16: consecutive cycles with neither pcpi_busy nor pcpi_ready before an issued instruction is declared illegal; legal range 2..255.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered by the core.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_insn  in  32  instruction word.
- cmd_rs1, cmd_rs2  in  32 each  operand values.
- pcpi_valid  out  1  request to the coprocessor.
- pcpi_insn, pcpi_rs1, pcpi_rs2  out  32 each  registered request payload.
- pcpi_wr  in  1  coprocessor writes rd; sampled only with pcpi_ready.
- pcpi_rd  in  32  coprocessor result.
- pcpi_busy  in  1  coprocessor has claimed the instruction.
- pcpi_ready  in  1  single-cycle completion pulse.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  core consumes the response.
- rsp_wr  out  1  write rd.
- rsp_rd  out  32  result.
- rsp_illegal  out  1  no coprocessor claimed the instruction.
- last_latency  out  CNT_W  cycles from the first pcpi_valid cycle to completion of the last operation, saturating.
- illegal_count  out  CNT_W  number of timeouts since reset, saturating.

## Operation
- FSM states are IDLE, ISSUE and RESP. Reset puts the FSM in IDLE.
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid, register insn/rs1/rs2 onto the pcpi_* outputs and go to ISSUE.
- **ISSUE**
  - pcpi_valid=1, payload held stable. cmd_ready=0.
  - Each cycle, the latency counter increments and saturates at all-ones.
  - A sticky claimed flag is set on the first cycle pcpi_busy=1.
  - While claimed=0, a timeout counter increments on each cycle with pcpi_busy=0 and pcpi_ready=0.
  - pcpi_ready=1: capture pcpi_wr and pcpi_rd into rsp_wr and rsp_rd, set rsp_illegal=0, copy the latency to last_latency, go to RESP.
  - Timeout counter reaches TIMEOUT with claimed=0: set rsp_illegal=1, rsp_wr=0, rsp_rd=0, increment illegal_count (saturating), update last_latency, go to RESP.
- **RESP**
  - rsp_valid=1, pcpi_valid=0, response held stable.
  - On rsp_ready, go to IDLE.
- pcpi_ready or pcpi_busy in IDLE or RESP is ignored; it has no effect on any state or counter.
- Once claimed=1 there is no timeout; the block waits indefinitely for pcpi_ready.
- Priority within one cycle: pcpi_ready > pcpi_busy > timeout.
  - ready and busy together: completion.
  - busy on the same cycle the timeout would fire: claimed, no timeout.

## Timing
- Reset values: cmd_ready=1 (IDLE). All other outputs are 0: pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, rsp_valid, rsp_wr, rsp_rd, rsp_illegal, last_latency, illegal_count.
- cmd_ready is a decode of state IDLE only, with no combinational path from any input.
- Command accepted at edge t: pcpi_valid=1 for the cycle after t.
- Latency N: the number of cycles pcpi_valid was high, counting the cycle pcpi_ready was sampled.
  - pcpi_ready is legal on the first pcpi_valid cycle, giving N=1.
- pcpi_ready sampled at edge k: pcpi_valid=0 and rsp_valid=1 from k onward. pcpi_valid is therefore never high in the cycle after ready.
- Timeout: with no busy and no ready, pcpi_valid is high for exactly TIMEOUT cycles, then rsp_valid rises; last_latency=TIMEOUT.
- rsp_valid with rsp_ready sampled at edge m: rsp_valid=0 and cmd_ready=1 after m. The next pcpi_valid comes no earlier than 2 cycles after m.
- Reset asserted in any state: all outputs return to reset values at the next edge.
  - The in-flight operation is dropped and no response is produced.
  - A late pcpi_ready after reset is ignored.
  - The statistics counters clear.

## Test plan
- **MUL, busy then ready.** cmd insn=0x02B50533, rs1=7, rs2=6. Model responder asserts busy for 3 cycles, then ready with wr=1, rd=42.
  - Required: rsp_valid with rsp_rd=42, rsp_wr=1, rsp_illegal=0, last_latency=4.
  - Required: pcpi payload stable throughout, and pcpi_valid low in the cycle after ready.
- **Ready in the first cycle.** Responder asserts ready combinationally in the first pcpi_valid cycle with rd=0xDEADBEEF.
  - Required: rsp_rd=0xDEADBEEF and last_latency=1.
- **Unclaimed instruction.** insn=0x0000000B with no responder activity, TIMEOUT=16.
  - Required: pcpi_valid high exactly 16 cycles, then rsp_illegal=1, rsp_rd=0, rsp_wr=0, illegal_count=1.
- **Timeout race.**
  - Busy asserted only in cycle 16, followed by ready 20 cycles later: no timeout, normal response, illegal_count unchanged.
  - Ready and busy together in cycle 16: completion with rsp_illegal=0.
- **Response back-pressure.** rsp_ready held low for 5 cycles while cmd_valid stays high and stray pcpi_ready pulses arrive.
  - Required: response held stable, cmd_ready=0, no second issue.
  - Required: after rsp_ready, the next command is accepted and pcpi_valid rises 2 cycles after the rsp handshake edge.
- **Reset mid-operation.** Reset for 1 cycle while in ISSUE with busy=1, then the responder pulses ready.
  - Required: all outputs at reset values, no rsp_valid, counters 0, and a subsequent command completes normally.

Source files
------------

// File: rtl/pcpi_initiator.sv
// pcpi_initiator: issues one instruction at a time to a PCPI coprocessor.
// It waits for pcpi_ready, or flags the instruction illegal when nothing claims
// it within TIMEOUT cycles. The result is returned on a valid/ready port, and
// latency and illegal-instruction statistics are kept.
module pcpi_initiator #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_insn,
    input  logic [31:0]      cmd_rs1,
    input  logic [31:0]      cmd_rs2,
    output logic             pcpi_valid,
    output logic [31:0]      pcpi_insn,
    output logic [31:0]      pcpi_rs1,
    output logic [31:0]      pcpi_rs2,
    input  logic             pcpi_wr,
    input  logic [31:0]      pcpi_rd,
    input  logic             pcpi_busy,
    input  logic             pcpi_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_wr,
    output logic [31:0]      rsp_rd,
    output logic             rsp_illegal,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] illegal_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        insn_q, insn_d;
    logic [31:0]        rs1_q, rs1_d;
    logic [31:0]        rs2_q, rs2_d;
    logic               rsp_wr_q, rsp_wr_d;
    logic [31:0]        rsp_rd_q, rsp_rd_d;
    logic               rsp_illegal_q, rsp_illegal_d;
    logic               claimed_q, claimed_d;
    logic [7:0]         tmo_q, tmo_d;
    logic [CNT_W-1:0]   lat_q, lat_d;
    logic [CNT_W-1:0]   last_lat_q, last_lat_d;
    logic [CNT_W-1:0]   ill_cnt_q, ill_cnt_d;

    // Handshake flags are pure state decodes, so no input reaches them combinationally.
    assign cmd_ready     = (state_q == S_IDLE);
    assign pcpi_valid    = (state_q == S_ISSUE);
    assign rsp_valid     = (state_q == S_RESP);
    assign pcpi_insn     = insn_q;
    assign pcpi_rs1      = rs1_q;
    assign pcpi_rs2      = rs2_q;
    assign rsp_wr        = rsp_wr_q;
    assign rsp_rd        = rsp_rd_q;
    assign rsp_illegal   = rsp_illegal_q;
    assign last_latency  = last_lat_q;
    assign illegal_count = ill_cnt_q;

    // Next-state, payload capture, timeout and statistics logic.
    always_comb begin
        state_d       = state_q;
        insn_d        = insn_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rsp_wr_d      = rsp_wr_q;
        rsp_rd_d      = rsp_rd_q;
        rsp_illegal_d = rsp_illegal_q;
        claimed_d     = claimed_q;
        tmo_d         = tmo_q;
        lat_d         = lat_q;
        last_lat_d    = last_lat_q;
        ill_cnt_d     = ill_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    insn_d    = cmd_insn;
                    rs1_d     = cmd_rs1;
                    rs2_d     = cmd_rs2;
                    claimed_d = 1'b0;
                    tmo_d     = '0;
                    // The count includes the first pcpi_valid cycle.
                    lat_d     = CNT_W'(1);
                    state_d   = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (lat_q != '1) begin
                    lat_d = lat_q + CNT_W'(1);
                end
                // ready beats busy, and busy beats the timeout in the same cycle.
                if (pcpi_ready) begin
                    rsp_wr_d      = pcpi_wr;
                    rsp_rd_d      = pcpi_rd;
                    rsp_illegal_d = 1'b0;
                    last_lat_d    = lat_q;
                    state_d       = S_RESP;
                end else if (pcpi_busy) begin
                    claimed_d = 1'b1;
                end else if (!claimed_q) begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_q == 8'(TIMEOUT - 1)) begin
                        rsp_wr_d      = 1'b0;
                        rsp_rd_d      = '0;
                        rsp_illegal_d = 1'b1;
                        last_lat_d    = lat_q;
                        if (ill_cnt_q != '1) begin
                            ill_cnt_d = ill_cnt_q + CNT_W'(1);
                        end
                        state_d = S_RESP;
                    end
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            insn_q        <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rsp_wr_q      <= 1'b0;
            rsp_rd_q      <= '0;
            rsp_illegal_q <= 1'b0;
            claimed_q     <= 1'b0;
            tmo_q         <= '0;
            lat_q         <= '0;
            last_lat_q    <= '0;
            ill_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            insn_q        <= insn_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rsp_wr_q      <= rsp_wr_d;
            rsp_rd_q      <= rsp_rd_d;
            rsp_illegal_q <= rsp_illegal_d;
            claimed_q     <= claimed_d;
            tmo_q         <= tmo_d;
            lat_q         <= lat_d;
            last_lat_q    <= last_lat_d;
            ill_cnt_q     <= ill_cnt_d;
        end
    end

endmodule

// File: tb/tb_pcpi_initiator.sv
// Bench for pcpi_initiator: directed scenarios followed by randomized operations.
// Expected results come from a per-operation model that only knows when busy
// and ready are asserted.
module tb_pcpi_initiator;

    localparam int unsigned TMO = 16;
    localparam int unsigned CW  = 16;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [31:0]   cmd_insn, cmd_rs1, cmd_rs2;
    logic          pcpi_valid;
    logic [31:0]   pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic          pcpi_wr;
    logic [31:0]   pcpi_rd;
    logic          pcpi_busy;
    logic          pcpi_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_wr;
    logic [31:0]   rsp_rd;
    logic          rsp_illegal;
    logic [CW-1:0] last_latency;
    logic [CW-1:0] illegal_count;

    int checks;
    int errors;
    int model_ill;

    pcpi_initiator #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_insn      (cmd_insn),
        .cmd_rs1       (cmd_rs1),
        .cmd_rs2       (cmd_rs2),
        .pcpi_valid    (pcpi_valid),
        .pcpi_insn     (pcpi_insn),
        .pcpi_rs1      (pcpi_rs1),
        .pcpi_rs2      (pcpi_rs2),
        .pcpi_wr       (pcpi_wr),
        .pcpi_rd       (pcpi_rd),
        .pcpi_busy     (pcpi_busy),
        .pcpi_ready    (pcpi_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_wr        (rsp_wr),
        .rsp_rd        (rsp_rd),
        .rsp_illegal   (rsp_illegal),
        .last_latency  (last_latency),
        .illegal_count (illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit busy_at(int c, int bs, int bl);
        return (bl > 0) && (c >= bs) && (c < bs + bl);
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"},   cmd_ready, 1);
        check({tag, "_pcpi_valid"},  pcpi_valid, 0);
        check({tag, "_pcpi_insn"},   pcpi_insn, 0);
        check({tag, "_pcpi_rs1"},    pcpi_rs1, 0);
        check({tag, "_pcpi_rs2"},    pcpi_rs2, 0);
        check({tag, "_rsp_valid"},   rsp_valid, 0);
        check({tag, "_rsp_wr"},      rsp_wr, 0);
        check({tag, "_rsp_rd"},      rsp_rd, 0);
        check({tag, "_rsp_illegal"}, rsp_illegal, 0);
        check({tag, "_last_lat"},    32'(last_latency), 0);
        check({tag, "_ill_cnt"},     32'(illegal_count), 0);
    endtask

    // One complete operation: issue, responder activity for cycles 1.., response,
    // optional back-pressure (with cmd_valid held high when keep=1), handshake.
    // bs/bl: busy from cycle bs for bl cycles; rc: ready cycle (0 = never).
    task automatic run_op(input string tag, input logic [31:0] insn, input logic [31:0] rs1,
                          input logic [31:0] rs2, input int bs, input int bl, input int rc,
                          input bit wr, input logic [31:0] rd, input int hold, input bit keep);
        bit exp_ill;
        int exp_lat;
        int n;
        bit bad;
        logic [31:0] exp_rd;
        bit exp_wr;

        // Model: illegal only if nothing at all happened in the first TMO cycles.
        exp_ill = 1'b1;
        for (int c = 1; c <= int'(TMO); c++) begin
            if (busy_at(c, bs, bl) || c == rc) exp_ill = 1'b0;
        end
        exp_lat = exp_ill ? int'(TMO) : rc;
        exp_rd  = exp_ill ? 32'h0 : rd;
        exp_wr  = exp_ill ? 1'b0 : wr;
        if (exp_ill) model_ill++;

        cmd_insn  = insn;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_valid = 1'b1;
        check({tag, "_idle_cmd_ready"}, cmd_ready, 1);
        check({tag, "_idle_pcpi_valid"}, pcpi_valid, 0);
        tick();
        cmd_valid = 1'b0;

        n   = 0;
        bad = 1'b0;
        while (pcpi_valid === 1'b1 && n < 400) begin
            n++;
            if (pcpi_insn !== insn || pcpi_rs1 !== rs1 || pcpi_rs2 !== rs2) bad = 1'b1;
            if (cmd_ready !== 1'b0) bad = 1'b1;
            pcpi_busy  = busy_at(n, bs, bl);
            pcpi_ready = (n == rc);
            pcpi_wr    = (n == rc) ? wr : ~wr;
            pcpi_rd    = (n == rc) ? rd : ~rd;
            tick();
        end
        pcpi_busy  = 1'b0;
        pcpi_ready = 1'b0;

        check({tag, "_valid_cycles"}, n, exp_lat);
        check({tag, "_payload_stable"}, bad, 0);
        check({tag, "_pcpi_valid_after"}, pcpi_valid, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_illegal"}, rsp_illegal, exp_ill);
        check({tag, "_rsp_wr"}, rsp_wr, exp_wr);
        check({tag, "_rsp_rd"}, rsp_rd, exp_rd);
        check({tag, "_last_latency"}, 32'(last_latency), exp_lat);
        check({tag, "_illegal_count"}, 32'(illegal_count), model_ill);

        for (int h = 0; h < hold; h++) begin
            cmd_valid  = keep;
            rsp_ready  = 1'b0;
            pcpi_ready = 1'($urandom_range(0, 1));
            pcpi_busy  = 1'($urandom_range(0, 1));
            pcpi_wr    = ~exp_wr;
            pcpi_rd    = ~exp_rd;
            tick();
            check({tag, "_hold_rsp_valid"}, rsp_valid, 1);
            check({tag, "_hold_cmd_ready"}, cmd_ready, 0);
            check({tag, "_hold_pcpi_valid"}, pcpi_valid, 0);
            check({tag, "_hold_rsp_rd"}, rsp_rd, exp_rd);
            check({tag, "_hold_rsp_wr"}, rsp_wr, exp_wr);
            check({tag, "_hold_illegal"}, rsp_illegal, exp_ill);
        end
        pcpi_ready = 1'b0;
        pcpi_busy  = 1'b0;
        cmd_valid  = keep;
        rsp_ready  = 1'b1;
        tick();
        rsp_ready  = 1'b0;
        check({tag, "_post_rsp_valid"}, rsp_valid, 0);
        check({tag, "_post_cmd_ready"}, cmd_ready, 1);
        check({tag, "_post_pcpi_valid"}, pcpi_valid, 0);
    endtask

    initial begin
        int bs, bl, rc, hold;
        checks     = 0;
        errors     = 0;
        model_ill  = 0;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_insn   = '0;
        cmd_rs1    = '0;
        cmd_rs2    = '0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = '0;
        pcpi_busy  = 1'b0;
        pcpi_ready = 1'b0;
        rsp_ready  = 1'b0;

        tick();
        tick();
        check_reset_vals("reset");
        reset = 1'b0;
        tick();

        // MUL with busy for 3 cycles, then ready.
        run_op("mul", 32'h02B50533, 32'd7, 32'd6, 1, 3, 4, 1'b1, 32'd42, 0, 1'b0);
        // Ready in the first pcpi_valid cycle.
        run_op("ready1", 32'h02C585B3, 32'h1234, 32'h5678, 0, 0, 1, 1'b1, 32'hDEADBEEF, 0, 1'b0);
        // Nobody claims the instruction.
        run_op("unclaimed", 32'h0000000B, 32'h11, 32'h22, 0, 0, 0, 1'b1, 32'hAAAA5555, 0, 1'b0);
        // Busy only in the cycle the timeout would fire, ready 20 cycles later.
        run_op("race_busy", 32'h02D60633, 32'h3, 32'h4, 16, 1, 36, 1'b1, 32'h0BADF00D, 0, 1'b0);
        // Busy and ready together in the timeout cycle.
        run_op("race_ready", 32'h02E686B3, 32'h5, 32'h6, 16, 1, 16, 1'b0, 32'h13579BDF, 0, 1'b0);
        // Back-pressure with cmd_valid held and stray ready pulses; next command follows.
        cmd_insn = 32'h02F70733;
        cmd_rs1  = 32'h77;
        cmd_rs2  = 32'h88;
        run_op("bp", 32'h02A50533, 32'h9, 32'h9, 2, 2, 3, 1'b1, 32'd81, 5, 1'b1);
        run_op("bp_next", 32'h02F70733, 32'h77, 32'h88, 0, 0, 2, 1'b1, 32'h3B98, 0, 1'b0);

        // Reset while the coprocessor holds busy, then a late ready.
        cmd_insn  = 32'h02B50533;
        cmd_rs1   = 32'hCAFE;
        cmd_rs2   = 32'hBEEF;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        pcpi_busy = 1'b1;
        tick();
        tick();
        check("midrst_in_issue", pcpi_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_ill = 0;
        check_reset_vals("midrst");
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        pcpi_rd    = 32'h55555555;
        tick();
        pcpi_ready = 1'b0;
        pcpi_busy  = 1'b0;
        check("late_ready_rsp_valid", rsp_valid, 0);
        check("late_ready_cmd_ready", cmd_ready, 1);
        check("late_ready_last_lat", 32'(last_latency), 0);
        run_op("after_rst", 32'h02B50533, 32'd3, 32'd5, 1, 1, 2, 1'b1, 32'd15, 0, 1'b0);

        // Randomized operations.
        for (int i = 0; i < 24; i++) begin
            rc = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40));
            if (rc != 0 && $urandom_range(0, 1) == 1) begin
                bs = int'($urandom_range(1, 24));
                bl = int'($urandom_range(1, 45));
            end else begin
                bs = 0;
                bl = 0;
            end
            hold = int'($urandom_range(0, 3));
            run_op($sformatf("rnd%0d", i), $urandom, $urandom, $urandom, bs, bl, rc,
                   1'($urandom_range(0, 1)), $urandom, hold, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
